// File: rtl/hack_pc_jump_unit.sv
// Hack CPU program-counter stage: ALU flag reduction, jump evaluation,
// next-PC selection and end-of-program (jump-to-self) halt detection.
module hack_pc_jump_unit #(
  parameter int WIDTH       = 16,
  parameter int HALT_DETECT = 1,
  parameter int HALT_REPEAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             c_instr,
  input  logic [2:0]       jump,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [WIDTH-1:0] a_reg,
  output logic [WIDTH-1:0] pc,
  output logic             zr,
  output logic             ng,
  output logic             jump_taken,
  output logic             halted
);

  localparam int HALF = WIDTH / 2;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] pc_nxt;
  logic [3:0]       self_cnt, self_cnt_nxt;
  logic [3:0]       self_cnt_inc;
  logic             cond;
  logic             self_jmp;
  logic             or_lo, or_hi;

  // Flag reduction and jump decision for the current instruction.
  always_comb begin
    or_lo      = |alu_out[HALF-1:0];
    or_hi      = |alu_out[WIDTH-1:HALF];
    zr         = ~(or_lo | or_hi);
    ng         = alu_out[WIDTH-1];
    halted     = (HALT_DETECT != 0) && (state == HALTED);
    cond       = (jump[2] & ng) | (jump[1] & zr) | (jump[0] & ~zr & ~ng);
    jump_taken = c_instr & cond & ~halted;
    // Only the unconditional form counts; a conditional jump to self is not a halt loop.
    self_jmp   = jump_taken & (jump == 3'b111) & (a_reg == pc);
  end

  // Next-state, next-PC and self-jump counter.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    self_cnt_nxt = self_cnt;
    self_cnt_inc = self_cnt + 4'd1;
    if (en && (state == RUN)) begin
      pc_nxt = jump_taken ? a_reg : pc + WIDTH'(1);
      if (HALT_DETECT == 0) begin
        self_cnt_nxt = '0;
      end else if (self_jmp) begin
        self_cnt_nxt = self_cnt_inc;
        if (self_cnt_inc == 4'(HALT_REPEAT))
          state_nxt = HALTED;
      end else begin
        self_cnt_nxt = '0;
      end
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      pc       <= '0;
      self_cnt <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      self_cnt <= self_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_hack_pc_jump_unit.sv
// Directed-vector bench for hack_pc_jump_unit.
module tb_hack_pc_jump_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        c_instr;
  logic [2:0]  jump;
  logic [15:0] alu_out;
  logic [15:0] a_reg;
  logic [15:0] pc;
  logic        zr, ng, jump_taken, halted;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  hack_pc_jump_unit #(
    .WIDTH      (16),
    .HALT_DETECT(1),
    .HALT_REPEAT(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .c_instr   (c_instr),
    .jump      (jump),
    .alu_out   (alu_out),
    .a_reg     (a_reg),
    .pc        (pc),
    .zr        (zr),
    .ng        (ng),
    .jump_taken(jump_taken),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One active edge, then settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic c, input logic [2:0] j,
                       input logic [15:0] alu, input logic [15:0] a);
    en = e; c_instr = c; jump = j; alu_out = alu; a_reg = a;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 3'b000, 16'h0000, 16'h0000);
    check("zr_in_reset", zr, 1);
    tick();
    check("rst_pc", pc, 16'h0000);
    check("rst_halted", halted, 0);
    reset = 1'b0;

    // 1: plain increment
    drive(1'b1, 1'b0, 3'b000, 16'h0001, 16'h0000);
    check("t1_taken", jump_taken, 0);
    tick(); check("t1_pc1", pc, 16'h0001);
    tick(); check("t1_pc2", pc, 16'h0002);
    tick(); check("t1_pc3", pc, 16'h0003);
    check("t1_halted", halted, 0);

    // 2: JEQ taken / not taken
    drive(1'b1, 1'b1, 3'b010, 16'h0000, 16'h0040);
    check("t2_zr", zr, 1);
    check("t2_taken", jump_taken, 1);
    tick(); check("t2_pc", pc, 16'h0040);
    drive(1'b1, 1'b1, 3'b010, 16'h0001, 16'h0040);
    check("t2_zr0", zr, 0);
    check("t2_ntaken", jump_taken, 0);
    tick(); check("t2_pc_inc", pc, 16'h0041);

    // 3: flag decode
    drive(1'b1, 1'b1, 3'b100, 16'h8000, 16'h0080);
    check("t3_ng", ng, 1);
    check("t3_zr", zr, 0);
    check("t3_jlt", jump_taken, 1);
    tick(); check("t3_jlt_pc", pc, 16'h0080);
    drive(1'b1, 1'b1, 3'b001, 16'h0005, 16'h0090);
    check("t3_jgt", jump_taken, 1);
    tick(); check("t3_jgt_pc", pc, 16'h0090);
    drive(1'b1, 1'b1, 3'b110, 16'h0005, 16'h0090);
    check("t3_jle_pos", jump_taken, 0);
    tick(); check("t3_jle_pc", pc, 16'h0091);
    drive(1'b0, 1'b1, 3'b000, 16'h0000, 16'h0020);
    check("t3_null_zero", jump_taken, 0);
    drive(1'b0, 1'b1, 3'b000, 16'h8000, 16'h0020);
    check("t3_null_neg", jump_taken, 0);
    drive(1'b0, 1'b1, 3'b000, 16'h0005, 16'h0020);
    check("t3_null_pos", jump_taken, 0);
    drive(1'b0, 1'b1, 3'b010, 16'h0100, 16'h0020);
    check("t3_zr_hi", zr, 0);
    check("t3_jeq_hi", jump_taken, 0);
    drive(1'b0, 1'b0, 3'b111, 16'h0000, 16'h0020);
    check("t3_not_cinstr", jump_taken, 0);

    // 4: wrap at 0xFFFF
    drive(1'b1, 1'b1, 3'b111, 16'h1234, 16'hFFFF);
    tick(); check("t4_pc_ffff", pc, 16'hFFFF);
    drive(1'b1, 1'b0, 3'b000, 16'h1234, 16'h0000);
    tick(); check("t4_wrap", pc, 16'h0000);

    // 5: halt detection
    drive(1'b1, 1'b1, 3'b111, 16'h0000, 16'h0010);
    tick(); check("t5_pc_load", pc, 16'h0010);
    check("t5_h_load", halted, 0);
    tick(); check("t5_h_self1", halted, 0);
    // conditional jump to self clears the count
    drive(1'b1, 1'b1, 3'b010, 16'h0000, 16'h0010);
    check("t5_cond_taken", jump_taken, 1);
    tick(); check("t5_cond_pc", pc, 16'h0010);
    check("t5_cond_h", halted, 0);
    drive(1'b1, 1'b1, 3'b111, 16'h0000, 16'h0010);
    tick(); check("t5_restart_h", halted, 0);
    en = 1'b0;
    tick(); check("t5_gap1_h", halted, 0);
    tick(); check("t5_gap2_h", halted, 0);
    check("t5_gap_pc", pc, 16'h0010);
    en = 1'b1;
    tick(); check("t5_halt", halted, 1);
    check("t5_halt_pc", pc, 16'h0010);
    check("t5_halt_taken", jump_taken, 0);
    drive(1'b1, 1'b0, 3'b000, 16'h0003, 16'h0077);
    tick(); check("t5_hold_pc1", pc, 16'h0010);
    tick(); check("t5_hold_pc2", pc, 16'h0010);
    check("t5_hold_h", halted, 1);

    // 6: async reset mid-cycle while halted
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("t6_pc_async", pc, 16'h0000);
    check("t6_h_async", halted, 0);
    @(negedge clk);
    reset = 1'b0;
    tick(); check("t6_pc_resume1", pc, 16'h0001);
    tick(); check("t6_pc_resume2", pc, 16'h0002);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
